// File: rtl/inst_predecode_queue.sv
// Instruction queue that classifies each word as it is written.
// Multi-slot enqueue at the tail, multi-slot presentation at the head.
module inst_predecode_queue #(
  parameter int FETCH_W    = 2,
  parameter int ISSUE_W    = 2,
  parameter int DEPTH      = 8,
  parameter int ENABLE_EXT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [FETCH_W-1:0]         in_valid,
  input  logic [32*FETCH_W-1:0]      in_inst,
  input  logic [32*FETCH_W-1:0]      in_pc,
  output logic                       in_ready,
  output logic [ISSUE_W-1:0]         out_valid,
  output logic [32*ISSUE_W-1:0]      out_inst,
  output logic [32*ISSUE_W-1:0]      out_pc,
  output logic [4*ISSUE_W-1:0]       out_class,
  input  logic [$clog2(ISSUE_W):0]   deq_num,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic EXT = (ENABLE_EXT != 0);

  localparam logic [3:0] C_ILL  = 4'd0;
  localparam logic [3:0] C_ALUR = 4'd1;
  localparam logic [3:0] C_ALUI = 4'd2;
  localparam logic [3:0] C_BR   = 4'd3;
  localparam logic [3:0] C_RBR  = 4'd4;
  localparam logic [3:0] C_RLNK = 4'd5;
  localparam logic [3:0] C_J    = 4'd6;
  localparam logic [3:0] C_JAL  = 4'd7;
  localparam logic [3:0] C_JR   = 4'd8;
  localparam logic [3:0] C_JALR = 4'd9;
  localparam logic [3:0] C_LD   = 4'd10;
  localparam logic [3:0] C_ST   = 4'd11;

  function automatic logic [3:0] classify(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic [3:0] c;
    op = w[31:26];
    fn = w[5:0];
    rt = w[20:16];
    c  = C_ILL;
    case (op)
      6'h00:
        case (fn)
          6'h20, 6'h21, 6'h22, 6'h24,
          6'h25, 6'h26, 6'h27: c = C_ALUR;
          6'h08: c = C_JR;
          6'h09: c = C_JALR;
          6'h00, 6'h02, 6'h03, 6'h04,
          6'h06, 6'h07, 6'h2a, 6'h2b:
            if (EXT) c = C_ALUR;
          default: c = C_ILL;
        endcase
      6'h01:
        case (rt)
          5'h00, 5'h01: c = C_RBR;
          5'h10, 5'h11: c = C_RLNK;
          default:      c = C_ILL;
        endcase
      6'h02: c = C_J;
      6'h03: c = C_JAL;
      6'h04, 6'h05, 6'h06, 6'h07: c = C_BR;
      6'h08, 6'h0c, 6'h0d, 6'h0e: c = C_ALUI;
      6'h0a, 6'h0b, 6'h0f:
        if (EXT) c = C_ALUI;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25:
        if (EXT) c = C_LD;
      6'h28, 6'h29, 6'h2b:
        if (EXT) c = C_ST;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic [3:0]    mem_cls  [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] free_n;
  logic [CW-1:0] n_acc;
  logic [CW-1:0] n_deq;
  logic [CW-1:0] deq_ext;
  logic [CW-1:0] lim;
  logic          run;

  assign free_n   = CW'(DEPTH) - count;
  assign in_ready = free_n >= CW'(FETCH_W);

  // Only the leading run of valid slots is taken.
  always_comb begin
    n_acc = '0;
    run   = in_ready;
    for (int i = 0; i < FETCH_W; i++) begin
      run = run & in_valid[i];
      if (run) n_acc = n_acc + CW'(1);
    end
  end

  always_comb begin
    deq_ext = CW'(deq_num);
    lim     = (count < CW'(ISSUE_W)) ? count : CW'(ISSUE_W);
    n_deq   = (deq_ext < lim) ? deq_ext : lim;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (!rst && !flush && CW'(i) < n_acc) begin
        mem_inst[tail + AW'(i)] <= in_inst[32*i +: 32];
        mem_pc[tail + AW'(i)]   <= in_pc[32*i +: 32];
        mem_cls[tail + AW'(i)]  <= classify(in_inst[32*i +: 32]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_deq);
      tail  <= tail + AW'(n_acc);
      count <= count + n_acc - n_deq;
    end
  end

  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    out_class = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (count > CW'(i)) begin
        out_valid[i]        = 1'b1;
        out_inst[32*i +: 32] = mem_inst[head + AW'(i)];
        out_pc[32*i +: 32]   = mem_pc[head + AW'(i)];
        out_class[4*i +: 4]  = mem_cls[head + AW'(i)];
      end
    end
  end

endmodule

// File: tb/tb_inst_predecode_queue.sv
// Directed bench for inst_predecode_queue, with the extended
// decode checked on a second instance sharing the same inputs.
module tb_inst_predecode_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  in_valid = '0;
  logic [63:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic [1:0]  deq_num = '0;

  logic        in_ready, x_in_ready;
  logic [1:0]  out_valid, x_out_valid;
  logic [63:0] out_inst, x_out_inst;
  logic [63:0] out_pc, x_out_pc;
  logic [7:0]  out_class, x_out_class;
  logic [3:0]  count, x_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_predecode_queue #(
    .FETCH_W(2), .ISSUE_W(2), .DEPTH(8), .ENABLE_EXT(0)
  ) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_inst(out_inst), .out_pc(out_pc),
    .out_class(out_class), .deq_num(deq_num), .count(count)
  );

  inst_predecode_queue #(
    .FETCH_W(2), .ISSUE_W(2), .DEPTH(8), .ENABLE_EXT(1)
  ) u_ext (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .in_ready(x_in_ready), .out_valid(x_out_valid),
    .out_inst(x_out_inst), .out_pc(x_out_pc),
    .out_class(x_out_class), .deq_num(deq_num), .count(x_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v,
                       input logic [31:0] i0, input logic [31:0] p0,
                       input logic [31:0] i1, input logic [31:0] p1);
    in_valid = v;
    in_inst  = {i1, i0};
    in_pc    = {p1, p0};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (count !== 4'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", count);
    end
    checks++;
    if (out_valid !== 2'b00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags got v=%b r=%b want v=00 r=1", out_valid, in_ready);
    end
    checks++;
    if (out_inst !== 64'h0 || out_pc !== 64'h0 || out_class !== 8'h0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h want 0", out_inst, out_pc, out_class);
    end
  endtask

  task automatic test_basic;
    drive(2'b11, 32'h00430820, 32'h100, 32'h10220004, 32'h104);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    checks++;
    if (out_valid !== 2'b11 || count !== 4'd2) begin
      errors++; $display("FAIL basic_valid got v=%b c=%0d want 11/2", out_valid, count);
    end
    checks++;
    if (out_class !== 8'h31) begin
      errors++; $display("FAIL basic_class got %h want 31", out_class);
    end
    checks++;
    if (out_pc !== {32'h104, 32'h100} || out_inst !== {32'h10220004, 32'h00430820}) begin
      errors++; $display("FAIL basic_data got %h %h", out_pc, out_inst);
    end
    deq_num = 2'd2;
    tick();
    deq_num = 2'd0;
    checks++;
    if (count !== 4'd0 || out_valid !== 2'b00) begin
      errors++; $display("FAIL basic_drain got c=%0d v=%b want 0/00", count, out_valid);
    end
  endtask

  task automatic test_full_wrap;
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 32'h200 + 8*k, 32'h200 + 8*k, 32'h204 + 8*k, 32'h204 + 8*k);
      tick();
    end
    checks++;
    if (count !== 4'd8 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_count got c=%0d r=%b want 8/0", count, in_ready);
    end
    drive(2'b11, 32'h300, 32'h300, 32'h304, 32'h304);
    tick();
    checks++;
    if (count !== 4'd8 || out_pc !== {32'h204, 32'h200}) begin
      errors++; $display("FAIL full_ignore got c=%0d pc=%h want 8", count, out_pc);
    end
    drive(2'b00, 0, 0, 0, 0);
    deq_num = 2'd2;
    tick();
    checks++;
    if (count !== 4'd6 || out_pc !== {32'h20c, 32'h208}) begin
      errors++; $display("FAIL full_deq got c=%0d pc=%h want 6", count, out_pc);
    end
    drive(2'b11, 32'h220, 32'h220, 32'h224, 32'h224);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    checks++;
    if (count !== 4'd6 || out_pc !== {32'h214, 32'h210}) begin
      errors++; $display("FAIL enq_deq got c=%0d pc=%h want 6 214/210", count, out_pc);
    end
    tick();
    checks++;
    if (count !== 4'd4 || out_pc !== {32'h21c, 32'h218}) begin
      errors++; $display("FAIL wrap_a got c=%0d pc=%h want 4 21c/218", count, out_pc);
    end
    tick();
    checks++;
    if (count !== 4'd2 || out_pc !== {32'h224, 32'h220} || out_inst !== {32'h224, 32'h220}) begin
      errors++; $display("FAIL wrap_b got c=%0d pc=%h want 2 224/220", count, out_pc);
    end
    tick();
    deq_num = 2'd0;
    checks++;
    if (count !== 4'd0 || out_valid !== 2'b00 || out_pc !== 64'h0) begin
      errors++; $display("FAIL wrap_empty got c=%0d v=%b pc=%h", count, out_valid, out_pc);
    end
  endtask

  task automatic test_flush;
    drive(2'b11, 32'h0, 32'h400, 32'h0, 32'h404);
    tick();
    drive(2'b11, 32'h0, 32'h408, 32'h0, 32'h40c);
    tick();
    drive(2'b01, 32'h0, 32'h410, 32'h0, 32'h414);
    tick();
    checks++;
    if (count !== 4'd5) begin
      errors++; $display("FAIL flush_pre got c=%0d want 5", count);
    end
    flush = 1'b1;
    deq_num = 2'd1;
    drive(2'b11, 32'h0, 32'h500, 32'h0, 32'h504);
    tick();
    flush = 1'b0;
    deq_num = 2'd0;
    drive(2'b00, 0, 0, 0, 0);
    checks++;
    if (count !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1 || out_pc !== 64'h0) begin
      errors++;
      $display("FAIL flush got c=%0d v=%b r=%b pc=%h want 0/00/1/0", count, out_valid, in_ready, out_pc);
    end
    drive(2'b01, 32'h00430820, 32'h600, 32'hffffffff, 32'hbad);
    tick();
    checks++;
    if (count !== 4'd1 || out_valid !== 2'b01 || out_pc !== {32'h0, 32'h600} || out_class !== 8'h01) begin
      errors++;
      $display("FAIL partial got c=%0d v=%b pc=%h cls=%h want 1/01", count, out_valid, out_pc, out_class);
    end
    drive(2'b10, 32'h0, 32'h700, 32'h0, 32'h704);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    checks++;
    if (count !== 4'd1 || out_pc !== {32'h0, 32'h600}) begin
      errors++; $display("FAIL slot0_gap got c=%0d pc=%h want 1", count, out_pc);
    end
  endtask

  task automatic test_classes;
    deq_num = 2'd2;
    tick();
    deq_num = 2'd0;
    checks++;
    if (count !== 4'd0 || out_valid !== 2'b00) begin
      errors++; $display("FAIL deq_clamp got c=%0d v=%b want 0/00", count, out_valid);
    end
    drive(2'b11, 32'h8c220000, 32'h800, 32'h04020000, 32'h804);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    checks++;
    if (out_class !== 8'h00) begin
      errors++; $display("FAIL lw_base got %h want 00", out_class);
    end
    checks++;
    if (x_out_class !== 8'h0a) begin
      errors++; $display("FAIL lw_ext got %h want 0a", x_out_class);
    end
    deq_num = 2'd2;
    drive(2'b11, 32'h04110000, 32'h808, 32'h03e00008, 32'h80c);
    tick();
    deq_num = 2'd0;
    drive(2'b00, 0, 0, 0, 0);
    checks++;
    if (out_class !== 8'h85 || x_out_class !== 8'h85) begin
      errors++; $display("FAIL link_jr got %h/%h want 85", out_class, x_out_class);
    end
    deq_num = 2'd2;
    drive(2'b11, 32'hac220000, 32'h810, 32'h00021080, 32'h814);
    tick();
    deq_num = 2'd0;
    drive(2'b00, 0, 0, 0, 0);
    checks++;
    if (out_class !== 8'h00 || x_out_class !== 8'h1b) begin
      errors++; $display("FAIL sw_sll got %h/%h want 00/1b", out_class, x_out_class);
    end
    deq_num = 2'd2;
    drive(2'b11, 32'h0c000000, 32'h818, 32'h3c010000, 32'h81c);
    tick();
    deq_num = 2'd0;
    drive(2'b00, 0, 0, 0, 0);
    checks++;
    if (out_class !== 8'h07 || x_out_class !== 8'h27) begin
      errors++; $display("FAIL jal_lui got %h/%h want 07/27", out_class, x_out_class);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_wrap();
    test_flush();
    test_classes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
